// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch unit (IF) and the load/store
// unit (LS). LS wins contention unless IF has waited STARVE_LIMIT LS grants.
// Grants and memory drive are combinational; responses come one cycle later.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr                  IF word-fetch request
//   if_gnt                          IF accepted this cycle
//   if_rvalid/if_rdata/if_err       IF response, one cycle after grant
//   ls_req/ls_we/ls_addr/ls_wdata   LS request (store when ls_we=1)
//   ls_size                         access size: 00=BYTE 01=HALF 10=WORD
//   ls_gnt                          LS accepted this cycle
//   ls_rvalid/ls_rdata/ls_err       LS response, one cycle after grant
//   mem_addr/mem_data_in            memory address / write data
//   mem_read/mem_write              memory strobes
//   mem_access_type                 memory access size
//   mem_data_out                    memory read data, valid cycle after mem_read
module mem_port_arbiter #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [DATA_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_err,
   input  logic                  ls_req,
   input  logic                  ls_we,
   input  logic [DATA_WIDTH-1:0] ls_addr,
   input  logic [DATA_WIDTH-1:0] ls_wdata,
   input  logic [1:0]            ls_size,
   output logic                  ls_gnt,
   output logic                  ls_rvalid,
   output logic [DATA_WIDTH-1:0] ls_rdata,
   output logic                  ls_err,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [1:0]            mem_access_type,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_LS   = 2'd2;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   logic [1:0]       owner, owner_nxt;
   logic             err_q, err_nxt;
   logic             store_q, store_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_nxt;
   logic             starve_hit;
   logic             if_mis, ls_mis;

   // Size 2'b11 is not a legal encoding; treat it with word alignment rules.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = lsb[0];
         default: misaligned = (lsb != 2'b00);
      endcase
   endfunction

   // Response owner, error flag and starvation count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner      <= OWN_NONE;
         err_q      <= 1'b0;
         store_q    <= 1'b0;
         starve_cnt <= '0;
      end else begin
         owner      <= owner_nxt;
         err_q      <= err_nxt;
         store_q    <= store_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Arbitration, memory drive, next owner and response routing.
   always_comb begin
      if_gnt          = 1'b0;
      ls_gnt          = 1'b0;
      if_rvalid       = 1'b0;
      if_rdata        = '0;
      if_err          = 1'b0;
      ls_rvalid       = 1'b0;
      ls_rdata        = '0;
      ls_err          = 1'b0;
      mem_addr        = '0;
      mem_data_in     = '0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_access_type = 2'b00;
      owner_nxt       = OWN_NONE;
      err_nxt         = 1'b0;
      store_nxt       = 1'b0;
      starve_nxt      = '0;
      starve_hit      = (starve_cnt == CNT_W'(STARVE_LIMIT));
      if_mis          = misaligned(SZ_WORD, if_addr[1:0]);
      ls_mis          = misaligned(ls_size, ls_addr[1:0]);

      // Everything is held quiet while reset is asserted, including a
      // response still sitting in the registers from before reset.
      if (rst_n) begin
         if (if_req && (!ls_req || starve_hit)) begin
            if_gnt          = 1'b1;
            mem_addr        = if_addr;
            mem_read        = !if_mis;
            mem_access_type = SZ_WORD;
            owner_nxt       = OWN_IF;
            err_nxt         = if_mis;
         end else if (ls_req) begin
            ls_gnt          = 1'b1;
            mem_addr        = ls_addr;
            mem_data_in     = ls_wdata;
            mem_read        = !ls_we && !ls_mis;
            mem_write       = ls_we && !ls_mis;
            mem_access_type = ls_size;
            owner_nxt       = OWN_LS;
            err_nxt         = ls_mis;
            store_nxt       = ls_we;
         end

         // Count LS wins over a waiting IF; any other cycle clears the count.
         if (ls_gnt && if_req) begin
            starve_nxt = starve_hit ? starve_cnt : starve_cnt + CNT_W'(1);
         end

         if (owner == OWN_IF) begin
            if_rvalid = 1'b1;
            if_err    = err_q;
            if_rdata  = err_q ? '0 : mem_data_out;
         end
         if (owner == OWN_LS) begin
            ls_rvalid = 1'b1;
            ls_err    = err_q;
            ls_rdata  = (err_q || store_q) ? '0 : mem_data_out;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a response scoreboard.
module tb_mem_port_arbiter;

   localparam logic [1:0] BYTE = 2'b00;
   localparam logic [1:0] HALF = 2'b01;
   localparam logic [1:0] WORD = 2'b10;
   localparam logic [1:0] W_NONE = 2'd0;
   localparam logic [1:0] W_IF   = 2'd1;
   localparam logic [1:0] W_LS   = 2'd2;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        ls_req, ls_we;
   logic [31:0] ls_addr, ls_wdata;
   logic [1:0]  ls_size;
   logic        ls_gnt, ls_rvalid, ls_err;
   logic [31:0] ls_rdata;
   logic [31:0] mem_addr, mem_data_in, mem_data_out;
   logic        mem_read, mem_write;
   logic [1:0]  mem_access_type;

   mem_port_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_size(ls_size), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
      .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_read(mem_read),
      .mem_write(mem_write), .mem_access_type(mem_access_type),
      .mem_data_out(mem_data_out)
   );

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        ls_req;
      logic        ls_we;
      logic [31:0] ls_addr;
      logic [31:0] ls_wdata;
      logic [1:0]  ls_size;
      logic        exp_if_gnt;
      logic        exp_ls_gnt;
   } vec_t;

   typedef struct {
      logic [1:0]  who;
      logic        err;
      logic [31:0] data;
      logic [31:0] exp_rdata;
   } rsp_t;

   rsp_t sb[$];
   int   passed = 0;
   int   total  = 0;
   int   cur_row = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s (step %0d): got 0x%08h want 0x%08h", name, cur_row, act, exp);
   endtask

   function automatic logic mis(input logic [1:0] size, input logic [31:0] addr);
      if (size == BYTE) return 1'b0;
      if (size == HALF) return addr[0];
      return addr[1:0] != 2'b00;
   endfunction

   function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic lr,
                               input logic we, input logic [31:0] la, input logic [31:0] wd,
                               input logic [1:0] sz, input logic eig, input logic elg);
      vec_t v;
      v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = we; v.ls_addr = la;
      v.ls_wdata = wd; v.ls_size = sz; v.exp_if_gnt = eig; v.exp_ls_gnt = elg;
      return v;
   endfunction

   function automatic rsp_t none_rsp();
      rsp_t r;
      r.who = W_NONE; r.err = 1'b0; r.data = $urandom; r.exp_rdata = '0;
      return r;
   endfunction

   // Drives one cycle (called at posedge+1), checks, then advances to next posedge+1.
   task automatic apply(input vec_t v);
      rsp_t r, n;
      logic e_read, e_write, m;
      if_req = v.if_req; if_addr = v.if_addr;
      ls_req = v.ls_req; ls_we = v.ls_we; ls_addr = v.ls_addr;
      ls_wdata = v.ls_wdata; ls_size = v.ls_size;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL sb_empty (step %0d): got 0 entries want 1", cur_row);
         r = none_rsp();
      end else begin
         r = sb.pop_front();
      end
      mem_data_out = r.data;
      #1;
      chk("if_gnt", 32'(if_gnt), 32'(v.exp_if_gnt));
      chk("ls_gnt", 32'(ls_gnt), 32'(v.exp_ls_gnt));
      chk("one_gnt", 32'(if_gnt & ls_gnt), 32'd0);
      n = none_rsp();
      e_read = 1'b0; e_write = 1'b0;
      if (v.exp_if_gnt) begin
         m = mis(WORD, v.if_addr);
         e_read = !m;
         chk("mem_addr_if", mem_addr, v.if_addr);
         chk("mem_type_if", 32'(mem_access_type), 32'(WORD));
         n.who = W_IF; n.err = m; n.exp_rdata = m ? 32'd0 : n.data;
      end else if (v.exp_ls_gnt) begin
         m = mis(v.ls_size, v.ls_addr);
         e_read = !v.ls_we && !m;
         e_write = v.ls_we && !m;
         chk("mem_addr_ls", mem_addr, v.ls_addr);
         chk("mem_data_in", mem_data_in, v.ls_wdata);
         chk("mem_type_ls", 32'(mem_access_type), 32'(v.ls_size));
         n.who = W_LS; n.err = m; n.exp_rdata = (m || v.ls_we) ? 32'd0 : n.data;
      end else begin
         chk("mem_addr_idle", mem_addr, 32'd0);
      end
      chk("mem_read", 32'(mem_read), 32'(e_read));
      chk("mem_write", 32'(mem_write), 32'(e_write));
      chk("if_rvalid", 32'(if_rvalid), 32'(r.who == W_IF));
      chk("if_rdata", if_rdata, (r.who == W_IF) ? r.exp_rdata : 32'd0);
      chk("ls_rvalid", 32'(ls_rvalid), 32'(r.who == W_LS));
      chk("ls_rdata", ls_rdata, (r.who == W_LS) ? r.exp_rdata : 32'd0);
      if (r.who == W_IF) chk("if_err", 32'(if_err), 32'(r.err));
      if (r.who == W_LS) chk("ls_err", 32'(ls_err), 32'(r.err));
      sb.push_back(n);
      @(posedge clk); #1;
      cur_row++;
   endtask

   // Holds reset with both requesters active and checks everything is quiet.
   task automatic reset_cycles(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         rst_n = 1'b0;
         if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
         if_addr = 32'h100; ls_addr = 32'h200; ls_wdata = 32'h1234_5678; ls_size = WORD;
         mem_data_out = $urandom;
         #1;
         chk("rst_if_gnt", 32'(if_gnt), 32'd0);
         chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
         chk("rst_mem_read", 32'(mem_read), 32'd0);
         chk("rst_mem_write", 32'(mem_write), 32'd0);
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_data_in", mem_data_in, 32'd0);
         chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
         chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
         chk("rst_if_rdata", if_rdata, 32'd0);
         chk("rst_ls_rdata", ls_rdata, 32'd0);
         @(posedge clk); #1;
         cur_row++;
      end
      sb.delete();
      sb.push_back(none_rsp());
      rst_n = 1'b1;
   endtask

   vec_t tbl[$];
   vec_t idle;

   initial begin
      rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_size = WORD; mem_data_out = '0;
      idle = mk(0, 32'h0, 0, 0, 32'h0, 32'h0, WORD, 0, 0);

      // fetch
      tbl.push_back(mk(1, 32'h8,  0, 0, 32'h0,  32'h0, WORD, 1, 0));
      tbl.push_back(idle);
      // contention then LS drops
      tbl.push_back(mk(1, 32'hC,  1, 0, 32'h20, 32'h0, WORD, 0, 1));
      tbl.push_back(mk(1, 32'hC,  0, 0, 32'h0,  32'h0, WORD, 1, 0));
      tbl.push_back(idle);
      // starvation guard at limit 4
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk(1, 32'h10, 1, 0, 32'h24, 32'h0, WORD, i == 4, i != 4));
      tbl.push_back(idle);
      // store, alignment cases
      tbl.push_back(mk(0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF, WORD, 0, 1));
      tbl.push_back(mk(0, 32'h0, 1, 0, 32'h3,  32'h0, HALF, 0, 1));
      tbl.push_back(mk(0, 32'h0, 1, 0, 32'h3,  32'h0, BYTE, 0, 1));
      tbl.push_back(mk(0, 32'h0, 1, 0, 32'h2,  32'h0, HALF, 0, 1));
      tbl.push_back(mk(0, 32'h0, 1, 0, 32'h2,  32'h0, WORD, 0, 1));
      tbl.push_back(mk(1, 32'h6, 0, 0, 32'h0,  32'h0, WORD, 1, 0));
      tbl.push_back(mk(0, 32'h0, 1, 1, 32'h11, 32'hCAFEF00D, WORD, 0, 1));
      tbl.push_back(mk(1, 32'h4, 1, 1, 32'h5,  32'h000000A5, BYTE, 0, 1));
      tbl.push_back(idle);

      @(posedge clk); #1;
      reset_cycles(2);
      foreach (tbl[i]) apply(tbl[i]);

      // reset while a load response is outstanding
      apply(mk(0, 32'h0, 1, 0, 32'h30, 32'h0, WORD, 0, 1));
      reset_cycles(2);
      apply(idle);
      apply(mk(1, 32'h40, 0, 0, 32'h0, 32'h0, WORD, 1, 0));
      apply(idle);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
